// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage F/D/X/M/W pipeline: operand forwarding, load-use/RAW
// stall, dcache-miss freeze, branch/jump flush, memory-wait timeout and perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REGW       = 5,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned MEM_TO_MAX = 15,
  parameter int unsigned CNTW       = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic            rs_use_d,
  input  logic            rt_use_d,
  input  logic [REGW-1:0] rs_x,
  input  logic [REGW-1:0] rt_x,
  input  logic [REGW-1:0] rw_x,
  input  logic            regwen_x,
  input  logic            memread_x,
  input  logic [REGW-1:0] rw_m,
  input  logic            regwen_m,
  input  logic            memread_m,
  input  logic            memwrite_m,
  input  logic            dhit,
  input  logic [REGW-1:0] rw_w,
  input  logic            regwen_w,
  input  logic [1:0]      jsel_x,
  input  logic            bne_x,
  input  logic            zero_x,
  output logic            pc_en,
  output logic            bubble_x,
  output logic            flush_fd,
  output logic            flush_dx,
  output logic            freeze,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            mem_timeout,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t      state, state_n;
  logic [15:0] wait_cnt, wait_n;
  logic        timeout_set;
  logic        dep_x, dep_m, lu, tk, mw;
  logic        fm_a, fw_a, fm_b, fw_b;

  // Register 0 is hardwired zero, so it never creates a dependency.
  assign dep_x = (rs_use_d && (rw_x != '0) && (rw_x == rs_d)) ||
                 (rt_use_d && (rw_x != '0) && (rw_x == rt_d));
  assign dep_m = (rs_use_d && (rw_m != '0) && (rw_m == rs_d)) ||
                 (rt_use_d && (rw_m != '0) && (rw_m == rt_d));

  assign lu = (FWD_EN != 0) ? (memread_x && regwen_x && dep_x)
                            : ((regwen_x && dep_x) || (regwen_m && dep_m));

  assign tk = (jsel_x == 2'd3) ? (bne_x ? !zero_x : zero_x) : (jsel_x != 2'd0);
  assign mw = (memread_m || memwrite_m) && !dhit;

  assign fm_a = regwen_m && (rw_m != '0) && (rw_m == rs_x);
  assign fw_a = regwen_w && (rw_w != '0) && (rw_w == rs_x);
  assign fm_b = regwen_m && (rw_m != '0) && (rw_m == rt_x);
  assign fw_b = regwen_w && (rw_w != '0) && (rw_w == rt_x);

  always_comb begin
    pc_en    = 1'b1;
    bubble_x = 1'b0;
    flush_fd = 1'b0;
    flush_dx = 1'b0;
    freeze   = 1'b0;
    fwd_a    = 2'd0;
    fwd_b    = 2'd0;
    if (!RST) begin
      if (FWD_EN != 0) begin
        fwd_a = fm_a ? 2'd1 : (fw_a ? 2'd2 : 2'd0);
        fwd_b = fm_b ? 2'd1 : (fw_b ? 2'd2 : 2'd0);
      end
      // Freeze wins outright; a branch held in X is re-evaluated once released.
      freeze = mw;
      if (mw) begin
        pc_en = 1'b0;
      end else if (tk) begin
        flush_fd = 1'b1;
        flush_dx = 1'b1;
      end else if (lu) begin
        pc_en    = 1'b0;
        bubble_x = 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt;
    timeout_set = 1'b0;
    case (state)
      S_RUN: begin
        if (mw) begin
          state_n = S_WAIT;
          wait_n  = 16'd1;
        end
      end
      S_WAIT: begin
        timeout_set = mw && (wait_cnt == 16'(MEM_TO_MAX));
        if (dhit) begin
          state_n = S_RUN;
          wait_n  = '0;
        end else if (wait_cnt != '1) begin
          wait_n = wait_cnt + 16'd1;
        end
      end
      default: begin
        state_n = S_RUN;
        wait_n  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      mem_timeout <= mem_timeout || timeout_set;
      if ((freeze || bubble_x) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNTW'(1);
      if (flush_fd && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (forwarding on, short timeout, 8-bit counters;
// forwarding off, default timeout, 32-bit counters) checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs_d, rt_d;
    logic       rs_use_d, rt_use_d;
    logic [4:0] rs_x, rt_x, rw_x;
    logic       regwen_x, memread_x;
    logic [4:0] rw_m;
    logic       regwen_m, memread_m, memwrite_m, dhit;
    logic [4:0] rw_w;
    logic       regwen_w;
    logic [1:0] jsel_x;
    logic       bne_x, zero_x;
  } in_t;

  typedef struct packed {
    logic       pc_en, bubble, flush_fd, flush_dx, freeze;
    logic [1:0] fwd_a, fwd_b;
  } out_t;

  typedef struct {
    in_t        in;
    logic       pc_en, bubble, flush_fd, flush_dx;
    logic [1:0] fwd_a, fwd_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  cur, z;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  logic       a_pc_en, a_bubble, a_flush_fd, a_flush_dx, a_freeze, a_tmo;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic [7:0] a_scnt, a_fcnt;
  logic       b_pc_en, b_bubble, b_flush_fd, b_flush_dx, b_freeze, b_tmo;
  logic [1:0] b_fwd_a, b_fwd_b;
  logic [31:0] b_scnt, b_fcnt;

  pipeline_hazard_ctrl #(.REGW(5), .FWD_EN(1), .MEM_TO_MAX(3), .CNTW(8)) dut_a (
    .CLK(clk), .RST(rst),
    .rs_d(cur.rs_d), .rt_d(cur.rt_d), .rs_use_d(cur.rs_use_d), .rt_use_d(cur.rt_use_d),
    .rs_x(cur.rs_x), .rt_x(cur.rt_x), .rw_x(cur.rw_x), .regwen_x(cur.regwen_x),
    .memread_x(cur.memread_x), .rw_m(cur.rw_m), .regwen_m(cur.regwen_m),
    .memread_m(cur.memread_m), .memwrite_m(cur.memwrite_m), .dhit(cur.dhit),
    .rw_w(cur.rw_w), .regwen_w(cur.regwen_w), .jsel_x(cur.jsel_x), .bne_x(cur.bne_x),
    .zero_x(cur.zero_x),
    .pc_en(a_pc_en), .bubble_x(a_bubble), .flush_fd(a_flush_fd), .flush_dx(a_flush_dx),
    .freeze(a_freeze), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .mem_timeout(a_tmo),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  pipeline_hazard_ctrl #(.REGW(5), .FWD_EN(0), .MEM_TO_MAX(15), .CNTW(32)) dut_b (
    .CLK(clk), .RST(rst),
    .rs_d(cur.rs_d), .rt_d(cur.rt_d), .rs_use_d(cur.rs_use_d), .rt_use_d(cur.rt_use_d),
    .rs_x(cur.rs_x), .rt_x(cur.rt_x), .rw_x(cur.rw_x), .regwen_x(cur.regwen_x),
    .memread_x(cur.memread_x), .rw_m(cur.rw_m), .regwen_m(cur.regwen_m),
    .memread_m(cur.memread_m), .memwrite_m(cur.memwrite_m), .dhit(cur.dhit),
    .rw_w(cur.rw_w), .regwen_w(cur.regwen_w), .jsel_x(cur.jsel_x), .bne_x(cur.bne_x),
    .zero_x(cur.zero_x),
    .pc_en(b_pc_en), .bubble_x(b_bubble), .flush_fd(b_flush_fd), .flush_dx(b_flush_dx),
    .freeze(b_freeze), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .mem_timeout(b_tmo),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  // Reference state per instance: index 0 = dut_a, 1 = dut_b.
  bit     m_fwd[2]  = '{1'b1, 1'b0};
  int     m_tomax[2] = '{3, 15};
  longint m_cmax[2] = '{64'd255, 64'hFFFF_FFFF};
  bit     m_wait[2];
  int     m_wcnt[2];
  bit     m_tmo[2];
  longint m_scnt[2], m_fcnt[2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit same_reg(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic bit reads(input in_t v, input logic [4:0] r);
    return (v.rs_use_d && same_reg(v.rs_d, r)) || (v.rt_use_d && same_reg(v.rt_d, r));
  endfunction

  function automatic logic [1:0] src_sel(input in_t v, input logic [4:0] src, input bit fe);
    if (!fe) return 2'd0;
    if (v.regwen_m && same_reg(v.rw_m, src)) return 2'd1;
    if (v.regwen_w && same_reg(v.rw_w, src)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic out_t model_out(input in_t v, input bit r, input bit fe);
    out_t o;
    bit   hazard, taken, miss;
    o = '{pc_en: 1'b1, bubble: 1'b0, flush_fd: 1'b0, flush_dx: 1'b0, freeze: 1'b0,
          fwd_a: 2'd0, fwd_b: 2'd0};
    if (r) return o;
    o.fwd_a = src_sel(v, v.rs_x, fe);
    o.fwd_b = src_sel(v, v.rt_x, fe);
    if (fe) hazard = v.memread_x && v.regwen_x && reads(v, v.rw_x);
    else    hazard = (v.regwen_x && reads(v, v.rw_x)) || (v.regwen_m && reads(v, v.rw_m));
    case (v.jsel_x)
      2'd0:    taken = 1'b0;
      2'd3:    taken = v.bne_x ? !v.zero_x : v.zero_x;
      default: taken = 1'b1;
    endcase
    miss = (v.memread_m || v.memwrite_m) && !v.dhit;
    if (miss) begin
      o.freeze = 1'b1;
      o.pc_en  = 1'b0;
    end else if (taken) begin
      o.flush_fd = 1'b1;
      o.flush_dx = 1'b1;
    end else if (hazard) begin
      o.pc_en  = 1'b0;
      o.bubble = 1'b1;
    end
    return o;
  endfunction

  task automatic model_edge(input int k, input out_t o);
    bit miss;
    if (rst) begin
      m_wait[k] = 0; m_wcnt[k] = 0; m_tmo[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
      return;
    end
    if ((o.freeze || o.bubble) && m_scnt[k] < m_cmax[k]) m_scnt[k]++;
    if (o.flush_fd && m_fcnt[k] < m_cmax[k]) m_fcnt[k]++;
    miss = (cur.memread_m || cur.memwrite_m) && !cur.dhit;
    if (!m_wait[k]) begin
      if (miss) begin m_wait[k] = 1; m_wcnt[k] = 1; end
    end else begin
      if (miss && m_wcnt[k] == m_tomax[k]) m_tmo[k] = 1;
      if (cur.dhit) begin m_wait[k] = 0; m_wcnt[k] = 0; end
      else if (m_wcnt[k] < 65535) m_wcnt[k]++;
    end
  endtask

  task automatic step();
    out_t o[2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) o[k] = model_out(cur, rst, m_fwd[k]);
    check("a.pc_en", a_pc_en, o[0].pc_en);       check("b.pc_en", b_pc_en, o[1].pc_en);
    check("a.bubble_x", a_bubble, o[0].bubble);  check("b.bubble_x", b_bubble, o[1].bubble);
    check("a.flush_fd", a_flush_fd, o[0].flush_fd); check("b.flush_fd", b_flush_fd, o[1].flush_fd);
    check("a.flush_dx", a_flush_dx, o[0].flush_dx); check("b.flush_dx", b_flush_dx, o[1].flush_dx);
    check("a.freeze", a_freeze, o[0].freeze);    check("b.freeze", b_freeze, o[1].freeze);
    check("a.fwd_a", a_fwd_a, o[0].fwd_a);       check("b.fwd_a", b_fwd_a, o[1].fwd_a);
    check("a.fwd_b", a_fwd_b, o[0].fwd_b);       check("b.fwd_b", b_fwd_b, o[1].fwd_b);
    check("a.mem_timeout", a_tmo, m_tmo[0]);     check("b.mem_timeout", b_tmo, m_tmo[1]);
    check("a.stall_cnt", a_scnt, m_scnt[0]);     check("b.stall_cnt", b_scnt, m_scnt[1]);
    check("a.flush_cnt", a_fcnt, m_fcnt[0]);     check("b.flush_cnt", b_fcnt, m_fcnt[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, o[k]);
    #1;
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.rs_d = 5'($urandom_range(0, 3));  v.rt_d = 5'($urandom_range(0, 3));
    v.rs_use_d = 1'($urandom);          v.rt_use_d = 1'($urandom);
    v.rs_x = 5'($urandom_range(0, 3));  v.rt_x = 5'($urandom_range(0, 3));
    v.rw_x = 5'($urandom_range(0, 3));  v.regwen_x = 1'($urandom);
    v.memread_x = 1'($urandom);         v.rw_m = 5'($urandom_range(0, 3));
    v.regwen_m = 1'($urandom);          v.memread_m = ($urandom_range(0, 3) == 0);
    v.memwrite_m = ($urandom_range(0, 5) == 0);
    v.dhit = ($urandom_range(0, 3) != 0);
    v.rw_w = 5'($urandom_range(0, 3));  v.regwen_w = 1'($urandom);
    v.jsel_x = 2'($urandom);            v.bne_x = 1'($urandom);
    v.zero_x = 1'($urandom);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cur = rand_in();
      step();
    end
    check("rst.a.stall_cnt", a_scnt, 64'd0);
    check("rst.b.flush_cnt", b_fcnt, 64'd0);
    check("rst.a.mem_timeout", a_tmo, 64'd0);
    check("rst.a.pc_en", a_pc_en, 64'd1);
    check("rst.b.freeze", b_freeze, 64'd0);
    rst = 1'b0;
    cur = z;
    #1;
  endtask

  vec_t    tbl[$];
  in_t     v;
  bit      tmo_exp[6];

  initial begin
    z = '0;
    z.dhit = 1'b1;
    cur = z;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single-cycle vectors with hand-derived outputs for the forwarding instance.
    v = z; v.rs_x = 5; v.rt_x = 5; v.rw_m = 5; v.regwen_m = 1; v.rw_w = 5; v.regwen_w = 1;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1});
    v.regwen_m = 0;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2});
    v.regwen_m = 1; v.rw_m = 0; v.rw_w = 0;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
    v = z; v.rs_x = 5; v.rw_m = 5; v.regwen_m = 1; v.rt_x = 6; v.rw_w = 6; v.regwen_w = 1;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2});
    v = z; v.memread_x = 1; v.regwen_x = 1; v.rw_x = 3; v.rt_d = 3; v.rt_use_d = 1;
    tbl.push_back('{v, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0});
    v.rt_use_d = 0;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
    v.rw_x = 0; v.rs_d = 0; v.rs_use_d = 1;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
    v = z; v.jsel_x = 3; v.bne_x = 1; v.zero_x = 0;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0});
    v.zero_x = 1;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
    v.bne_x = 0;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0});
    v.jsel_x = 2;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0});
    v = z; v.jsel_x = 1; v.memread_x = 1; v.regwen_x = 1; v.rw_x = 3; v.rt_d = 3; v.rt_use_d = 1;
    tbl.push_back('{v, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0});

    foreach (tbl[i]) begin
      cur = tbl[i].in;
      #1;
      check($sformatf("vec%0d.pc_en", i), a_pc_en, tbl[i].pc_en);
      check($sformatf("vec%0d.bubble_x", i), a_bubble, tbl[i].bubble);
      check($sformatf("vec%0d.flush_fd", i), a_flush_fd, tbl[i].flush_fd);
      check($sformatf("vec%0d.flush_dx", i), a_flush_dx, tbl[i].flush_dx);
      check($sformatf("vec%0d.fwd_a", i), a_fwd_a, tbl[i].fwd_a);
      check($sformatf("vec%0d.fwd_b", i), a_fwd_b, tbl[i].fwd_b);
      step();
    end

    // Load in X followed by a dependent read: one stall cycle.
    do_reset();
    cur.memread_x = 1; cur.regwen_x = 1; cur.rw_x = 3; cur.rt_d = 3; cur.rt_use_d = 1;
    step();
    cur = z;
    step();
    check("lu.a.stall_cnt", a_scnt, 64'd1);

    // Without forwarding an ADD stalls while in X and again while in M.
    do_reset();
    cur.regwen_x = 1; cur.rw_x = 3; cur.rt_d = 3; cur.rt_use_d = 1;
    step();
    cur.regwen_x = 0; cur.rw_m = 3; cur.regwen_m = 1;
    step();
    cur.regwen_m = 0; cur.rw_w = 3; cur.regwen_w = 1;
    #1;
    check("raw.b.pc_en_after", b_pc_en, 64'd1);
    step();
    check("raw.b.stall_cnt", b_scnt, 64'd2);
    check("raw.a.stall_cnt", a_scnt, 64'd0);

    // Miss with a jump waiting in X: frozen for 4 cycles, flush only on release.
    do_reset();
    cur.memread_m = 1; cur.dhit = 0; cur.jsel_x = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("miss%0d.freeze", i), b_freeze, 64'd1);
      check($sformatf("miss%0d.flush_fd", i), b_flush_fd, 64'd0);
      step();
    end
    cur.dhit = 1;
    #1;
    check("miss.release.freeze", b_freeze, 64'd0);
    check("miss.release.flush_fd", b_flush_fd, 64'd1);
    step();
    check("miss.b.mem_timeout", b_tmo, 64'd0);

    // Timeout with a limit of 3: sets once the wait count is 3 and the miss persists.
    do_reset();
    tmo_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    cur.memread_m = 1; cur.dhit = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("tmo%0d", i), a_tmo, tmo_exp[i]);
    end
    cur.dhit = 1;
    step();
    step();
    check("tmo.sticky", a_tmo, 64'd1);
    rst = 1;
    step();
    check("tmo.rst_clear", a_tmo, 64'd0);

    // Reset in mid-wait restarts the wait count from scratch.
    rst = 0; cur.dhit = 0;
    step();
    step();
    rst = 1;
    #1;
    check("midrst.freeze_in_rst", a_freeze, 64'd0);
    step();
    rst = 0;
    #1;
    check("midrst.freeze_follows_mw", a_freeze, 64'd1);
    for (int i = 0; i < 3; i++) step();
    check("midrst.tmo_not_yet", a_tmo, 64'd0);
    step();
    check("midrst.tmo_set", a_tmo, 64'd1);
    cur.dhit = 1;
    #1;
    check("midrst.freeze_off", a_freeze, 64'd0);
    step();

    // Counter saturation (8-bit instance) versus plain counting (32-bit instance).
    do_reset();
    cur.memread_m = 1; cur.dhit = 0;
    for (int i = 0; i < 260; i++) step();
    check("sat.a.stall_cnt", a_scnt, 64'd255);
    check("sat.b.stall_cnt", b_scnt, 64'd260);
    do_reset();
    cur.jsel_x = 1;
    for (int i = 0; i < 260; i++) step();
    check("sat.a.flush_cnt", a_fcnt, 64'd255);
    check("sat.b.flush_cnt", b_fcnt, 64'd260);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cur = rand_in();
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
